// File: rtl/fsm_ctrl_pkg.sv
// Shared definitions for the fsm_ctrl control unit.
//   STATE_W   : width of the state code driven on fsm_ctrl.out
//   state_t   : state encoding (codes 10..15 are unused)
//   OP_*      : 3-bit instruction class codes in mnm_in[2:0]
//   ctrl_t    : bundle of the Moore control outputs
//   decode_op : maps a legal opcode to the state that follows FETCH
package fsm_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_PC     = 4'd0,
        S_FETCH  = 4'd1,
        S_LDR    = 4'd2,
        S_ARIT   = 4'd3,
        S_WB_RD  = 4'd4,
        S_LOGICA = 4'd5,
        S_WB_R0  = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    localparam logic [2:0] OP_LDR   = 3'b000;
    localparam logic [2:0] OP_LOGIC = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef struct packed {
        logic ena_pc;
        logic ld_pc;
        logic ena_ri;
        logic ena_wr;
        logic sel_r0_rd;
        logic sel_addr_data;
        logic sel_ldr_ula;
        logic ena_ula;
        logic halted;
        logic fault;
    } ctrl_t;

    // JZ resolves here: a taken branch reloads the PC, otherwise it is a plain increment.
    function automatic state_t decode_op(input logic [2:0] op, input logic zf);
        state_t nxt;
        case (op)
            OP_LDR:          nxt = S_LDR;
            OP_LOGIC:        nxt = S_LOGICA;
            OP_ADD, OP_SUB:  nxt = S_ARIT;
            OP_JMP:          nxt = S_JUMP;
            OP_JZ:           nxt = zf ? S_JUMP : S_PC;
            OP_NOP:          nxt = S_PC;
            OP_HALT:         nxt = S_HALT;
            default:         nxt = S_FAULT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm_ctrl_ack_watchdog.sv
// Per-state ack watchdog.
//   clk, rst : clock, synchronous active-high reset
//   clr      : state-change strobe; restarts the count for the new state
//   wait_en  : current state is waiting on an ack
//   ack      : the ack the current state waits for
//   expire   : combinational; this is the last permitted cycle and ack is still low
// TIMEOUT = 0 disables the watchdog (counter held at 0, expire never set).
module ack_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic wait_en,
    input  logic ack,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic ENABLED = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] count;

    // The count never passes LAST: expiring forces a state change, which clears it.
    always_ff @(posedge clk) begin
        if (rst || clr || !ENABLED) begin
            count <= '0;
        end else if (wait_en && !ack) begin
            count <= count + 1'b1;
        end
    end

    // Gated by !ack so an ack arriving on the last cycle still wins.
    assign expire = ENABLED && wait_en && !ack && (count == LAST);

endmodule

// File: rtl/fsm_ctrl.sv
// Moore control FSM for the microcore: fetch, decode, execute, write-back,
// plus JMP / JZ / NOP / HALT and a sticky FAULT state fed by an ack watchdog.
//   clk, rst        : clock, synchronous active-high reset
//   mnm_in          : opcode (OPC_W bits); bits above 2 set means illegal
//   zero_flag       : ALU zero flag, used by JZ in FETCH
//   ula_ack, wr_ack, pc_ack, ri_ack : completion acks of ALU, regfile, PC, IR
//   resume          : leaves HALT
//   ena_pc .. ena_ula : datapath enables / selects
//   halted, fault   : status flags
//   out             : current state code (debug / observation)
// Handshake: each waiting state holds its enables until the one ack it waits
// on is sampled high on a rising edge; acks seen in any other state are ignored.
module fsm_ctrl
    import fsm_ctrl_pkg::*;
#(
    parameter int OPC_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   mnm_in,
    input  logic               zero_flag,
    input  logic               ula_ack,
    input  logic               wr_ack,
    input  logic               pc_ack,
    input  logic               ri_ack,
    input  logic               resume,
    output logic               ena_pc,
    output logic               ld_pc,
    output logic               ena_ri,
    output logic               ena_wr,
    output logic               sel_r0_rd,
    output logic               sel_addr_data,
    output logic               sel_ldr_ula,
    output logic               ena_ula,
    output logic               halted,
    output logic               fault,
    output logic [STATE_W-1:0] out
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   ack_sel;
    logic   wait_en;
    logic   expire;
    logic   illegal;
    logic   state_change;

    generate
        if (OPC_W > 3) begin : g_wide_opc
            assign illegal = |mnm_in[OPC_W-1:3];
        end else begin : g_narrow_opc
            assign illegal = 1'b0;
        end
    endgenerate

    // Which ack the current state waits on; HALT, FAULT and unused codes do not wait.
    always_comb begin
        ack_sel = 1'b0;
        wait_en = 1'b1;
        case (state)
            S_PC, S_JUMP:              ack_sel = pc_ack;
            S_FETCH:                   ack_sel = ri_ack;
            S_LDR, S_WB_RD, S_WB_R0:   ack_sel = wr_ack;
            S_ARIT, S_LOGICA:          ack_sel = ula_ack;
            default:                   wait_en = 1'b0;
        endcase
    end

    ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_change),
        .wait_en (wait_en),
        .ack     (ack_sel),
        .expire  (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;
        case (state)
            S_PC: begin
                ctrl.ena_pc = 1'b1;
                if (pc_ack) next_state = S_FETCH;
            end
            S_JUMP: begin
                ctrl.ena_pc = 1'b1;
                ctrl.ld_pc  = 1'b1;
                if (pc_ack) next_state = S_FETCH;
            end
            S_FETCH: begin
                ctrl.ena_ri = 1'b1;
                if (ri_ack) next_state = illegal ? S_FAULT : decode_op(mnm_in[2:0], zero_flag);
            end
            S_LDR: begin
                ctrl.ena_wr      = 1'b1;
                ctrl.sel_r0_rd   = 1'b1;
                ctrl.sel_ldr_ula = 1'b1;
                if (wr_ack) next_state = S_PC;
            end
            S_ARIT: begin
                ctrl.sel_addr_data = 1'b1;
                ctrl.ena_ula       = 1'b1;
                if (ula_ack) next_state = S_WB_RD;
            end
            S_WB_RD: begin
                ctrl.ena_wr    = 1'b1;
                ctrl.sel_r0_rd = 1'b1;
                if (wr_ack) next_state = S_PC;
            end
            S_LOGICA: begin
                ctrl.sel_addr_data = 1'b1;
                ctrl.ena_ula       = 1'b1;
                if (ula_ack) next_state = S_WB_R0;
            end
            S_WB_R0: begin
                ctrl.ena_wr = 1'b1;
                if (wr_ack) next_state = S_PC;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
                if (resume) next_state = S_PC;
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
        // expire already implies the ack is low, so it never overrides a normal move.
        if (expire) next_state = S_FAULT;
    end

    assign state_change  = (next_state != state);

    assign ena_pc        = ctrl.ena_pc;
    assign ld_pc         = ctrl.ld_pc;
    assign ena_ri        = ctrl.ena_ri;
    assign ena_wr        = ctrl.ena_wr;
    assign sel_r0_rd     = ctrl.sel_r0_rd;
    assign sel_addr_data = ctrl.sel_addr_data;
    assign sel_ldr_ula   = ctrl.sel_ldr_ula;
    assign ena_ula       = ctrl.ena_ula;
    assign halted        = ctrl.halted;
    assign fault         = ctrl.fault;
    assign out           = state;

endmodule

// File: tb/tb_fsm_ctrl.sv
// Bench for fsm_ctrl. Two instances share stimulus:
//   dut0 : OPC_W = 3, TIMEOUT = 16
//   dut1 : OPC_W = 4, TIMEOUT = 4
// Each has its own reference model (state code + cycles spent in that state).
module tb_fsm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mnm = 4'd0;
    logic       zero_flag = 1'b0;
    logic       ula_ack = 1'b0;
    logic       wr_ack = 1'b0;
    logic       pc_ack = 1'b0;
    logic       ri_ack = 1'b0;
    logic       resume = 1'b0;

    // {ena_pc, ld_pc, ena_ri, ena_wr, sel_r0_rd, sel_addr_data, sel_ldr_ula, ena_ula, halted, fault}
    wire [9:0]  ctl0;
    wire [9:0]  ctl1;
    wire [3:0]  out0;
    wire [3:0]  out1;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_st[2]    = '{1, 1};
    int m_dwell[2] = '{0, 0};

    always #5 clk = ~clk;

    fsm_ctrl #(.OPC_W(3), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst), .mnm_in(mnm[2:0]), .zero_flag(zero_flag),
        .ula_ack(ula_ack), .wr_ack(wr_ack), .pc_ack(pc_ack), .ri_ack(ri_ack), .resume(resume),
        .ena_pc(ctl0[9]), .ld_pc(ctl0[8]), .ena_ri(ctl0[7]), .ena_wr(ctl0[6]),
        .sel_r0_rd(ctl0[5]), .sel_addr_data(ctl0[4]), .sel_ldr_ula(ctl0[3]),
        .ena_ula(ctl0[2]), .halted(ctl0[1]), .fault(ctl0[0]), .out(out0)
    );

    fsm_ctrl #(.OPC_W(4), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .mnm_in(mnm), .zero_flag(zero_flag),
        .ula_ack(ula_ack), .wr_ack(wr_ack), .pc_ack(pc_ack), .ri_ack(ri_ack), .resume(resume),
        .ena_pc(ctl1[9]), .ld_pc(ctl1[8]), .ena_ri(ctl1[7]), .ena_wr(ctl1[6]),
        .sel_r0_rd(ctl1[5]), .sel_addr_data(ctl1[4]), .sel_ldr_ula(ctl1[3]),
        .ena_ula(ctl1[2]), .halted(ctl1[1]), .fault(ctl1[0]), .out(out1)
    );

    // ---------------- reference model ----------------
    function automatic logic [9:0] exp_ctl(input int st);
        case (st)
            0:       return 10'b1000000000;  // ena_pc
            7:       return 10'b1100000000;  // ena_pc, ld_pc
            1:       return 10'b0010000000;  // ena_ri
            2:       return 10'b0001101000;  // ena_wr, sel_r0_rd, sel_ldr_ula
            3, 5:    return 10'b0000010100;  // sel_addr_data, ena_ula
            4:       return 10'b0001100000;  // ena_wr, sel_r0_rd
            6:       return 10'b0001000000;  // ena_wr
            8:       return 10'b0000000010;  // halted
            9:       return 10'b0000000001;  // fault
            default: return 10'b0000000000;
        endcase
    endfunction

    // The ack a state waits on, or 0 when it waits on none.
    function automatic logic awaited_ack(input int st);
        case (st)
            0, 7:    return pc_ack;
            1:       return ri_ack;
            2, 4, 6: return wr_ack;
            3, 5:    return ula_ack;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int after_ack(input int st, input int op);
        int dec[8];
        dec = '{2, 5, 3, 3, 7, 0, 0, 8};
        dec[5] = zero_flag ? 7 : 0;
        case (st)
            1:       return (op >= 8) ? 9 : dec[op];
            0, 7:    return 1;
            2:       return 0;
            3:       return 4;
            4, 6:    return 0;
            5:       return 6;
            default: return st;
        endcase
    endfunction

    task automatic model_update(input int k);
        int st;
        int nxt;
        int lim;
        int op;
        st  = m_st[k];
        lim = (k == 0) ? 16 : 4;
        op  = (k == 0) ? int'(mnm[2:0]) : int'(mnm);
        if (rst) begin
            m_st[k]    = 1;
            m_dwell[k] = 0;
            return;
        end
        if (st > 9)                                nxt = 1;
        else if (st == 8)                          nxt = resume ? 0 : 8;
        else if (st == 9)                          nxt = 9;
        else if (awaited_ack(st))                  nxt = after_ack(st, op);
        else if (lim > 0 && m_dwell[k] + 1 >= lim) nxt = 9;   // a state lasts at most lim cycles
        else                                       nxt = st;
        m_dwell[k] = (nxt == st) ? m_dwell[k] + 1 : 0;
        m_st[k]    = nxt;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check("dut0.out", 32'(out0), 32'(m_st[0]));
        check("dut0.ctl", 32'(ctl0), 32'(exp_ctl(m_st[0])));
        check("dut1.out", 32'(out1), 32'(m_st[1]));
        check("dut1.ctl", 32'(ctl1), 32'(exp_ctl(m_st[1])));
    endtask

    task automatic clear_inputs();
        ula_ack = 1'b0; wr_ack = 1'b0; pc_ack = 1'b0; ri_ack = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed then random stimulus ----------------
    initial begin
        do_reset();
        step();
        check("reset.out", 32'(out0), 32'd1);
        check("reset.ctl", 32'(ctl0), 32'b0010000000);

        // LDR: 1 -> 2 -> 0 -> 1
        mnm = 4'b0000; ri_ack = 1'b1; step(); clear_inputs();
        check("ldr.out", 32'(out0), 32'd2);
        check("ldr.ctl", 32'(ctl0), 32'b0001101000);
        wr_ack = 1'b1; step(); clear_inputs();
        check("ldr.pc", 32'(out0), 32'd0);
        pc_ack = 1'b1; step(); clear_inputs();
        check("ldr.fetch", 32'(out0), 32'd1);

        // ADD with ula_ack on the 4th ARIT cycle (last permitted cycle for dut1)
        mnm = 4'b0010; ri_ack = 1'b1; step(); clear_inputs();
        for (int i = 0; i < 3; i++) begin
            check("add.hold", 32'(out1), 32'd3);
            check("add.ena_ula", 32'(ctl1[2]), 32'd1);
            step();
        end
        check("add.hold", 32'(out1), 32'd3);
        ula_ack = 1'b1; step(); clear_inputs();
        check("add.ack_wins", 32'(out1), 32'd4);
        check("add.ula_off", 32'(ctl1[2]), 32'd0);
        wr_ack = 1'b1; step(); clear_inputs();
        check("add.pc", 32'(out0), 32'd0);
        pc_ack = 1'b1; step(); clear_inputs();

        // JZ taken
        mnm = 4'b0101; zero_flag = 1'b1; ri_ack = 1'b1; step(); clear_inputs();
        check("jz1.out", 32'(out0), 32'd7);
        check("jz1.ld_pc", 32'(ctl0[8]), 32'd1);
        check("jz1.ena_pc", 32'(ctl0[9]), 32'd1);
        pc_ack = 1'b1; step(); clear_inputs();
        check("jz1.fetch", 32'(out0), 32'd1);
        // JZ not taken
        zero_flag = 1'b0; ri_ack = 1'b1; step(); clear_inputs();
        check("jz0.out", 32'(out0), 32'd0);
        check("jz0.ld_pc", 32'(ctl0[8]), 32'd0);
        pc_ack = 1'b1; step(); clear_inputs();

        // NOP, then logic instruction through WB_R0
        mnm = 4'b0110; ri_ack = 1'b1; step(); clear_inputs();
        check("nop.out", 32'(out0), 32'd0);
        pc_ack = 1'b1; step(); clear_inputs();
        mnm = 4'b0001; ri_ack = 1'b1; step(); clear_inputs();
        check("logic.out", 32'(out0), 32'd5);
        ula_ack = 1'b1; step(); clear_inputs();
        check("logic.wb", 32'(out0), 32'd6);
        wr_ack = 1'b1; step(); clear_inputs();
        pc_ack = 1'b1; step(); clear_inputs();

        // HALT for 50 cycles with acks toggling, then resume
        mnm = 4'b0111; ri_ack = 1'b1; step(); clear_inputs();
        for (int i = 0; i < 50; i++) begin
            ula_ack = 1'($urandom); wr_ack = 1'($urandom);
            pc_ack  = 1'($urandom); ri_ack = 1'($urandom);
            step();
            check("halt.out", 32'(out1), 32'd8);
            check("halt.halted", 32'(ctl0[1]), 32'd1);
        end
        clear_inputs();
        resume = 1'b1; step(); clear_inputs();
        check("halt.resume", 32'(out0), 32'd0);
        pc_ack = 1'b1; step(); clear_inputs();

        // Timeout: ARIT without ula_ack; dut1 lasts exactly 4 cycles
        mnm = 4'b0011; ri_ack = 1'b1; step(); clear_inputs();
        for (int i = 0; i < 3; i++) begin
            check("to.arit", 32'(out1), 32'd3);
            step();
        end
        check("to.arit", 32'(out1), 32'd3);
        step();
        check("to.fault", 32'(out1), 32'd9);
        check("to.fault_bit", 32'(ctl1[0]), 32'd1);
        for (int i = 0; i < 14; i++) step();
        check("to16.fault", 32'(out0), 32'd9);
        resume = 1'b1; step(); clear_inputs();
        check("to.sticky", 32'(out1), 32'd9);
        do_reset();
        check("to.rst", 32'(out1), 32'd1);

        // Illegal opcode on the 4-bit instance; dut0 only sees 000 (LDR)
        mnm = 4'b1000; ri_ack = 1'b1; step(); clear_inputs();
        check("illegal.dut1", 32'(out1), 32'd9);
        check("illegal.dut0", 32'(out0), 32'd2);
        do_reset();

        // Random phase against the models
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mnm       = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(8, 15))
                                                     : 4'($urandom_range(0, 7));
            zero_flag = 1'($urandom);
            ula_ack   = ($urandom_range(0, 2) == 0);
            wr_ack    = ($urandom_range(0, 2) == 0);
            pc_ack    = ($urandom_range(0, 2) == 0);
            ri_ack    = ($urandom_range(0, 2) == 0);
            resume    = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_ctrl.md
Name: fsm_ctrl

Overview:
Parametrised successor of the microcore control FSM.
- Sequences fetch, decode, execute and write-back for an OPC_W-bit opcode field.
- Adds four instruction classes: unconditional jump (JMP), jump-if-zero (JZ), NOP and HALT.
- Adds a per-state ack watchdog that drops the core into a sticky FAULT state.
- Sits between the instruction register / ALU / register file / PC blocks and drives their enables as a Moore machine.

Parameters:
- OPC_W, 3, opcode width. Must be >= 3. If any bit above bit 2 is set, the opcode is illegal.
- TIMEOUT, 16, maximum cycles spent waiting for an ack in any waiting state. 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mnm_in  in  OPC_W  opcode from the instruction register, sampled in FETCH.
- zero_flag  in  1  ALU zero flag, sampled in FETCH for JZ.
- ula_ack  in  1  ALU done.
- wr_ack  in  1  register-file write done.
- pc_ack  in  1  PC update done.
- ri_ack  in  1  instruction register loaded.
- resume  in  1  single-cycle pulse that leaves HALT.
- ena_pc  out  1  PC enable.
- ld_pc  out  1  with ena_pc: load jump target instead of increment.
- ena_ri  out  1  IR load enable.
- ena_wr  out  1  register-file write enable.
- sel_r0_rd  out  1  write destination: 1 = RD, 0 = R0.
- sel_addr_data  out  1  ALU operand select.
- sel_ldr_ula  out  1  write-data select: 1 = immediate (LDR), 0 = ALU.
- ena_ula  out  1  ALU enable.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- out  out  4  current state code.

Behaviour:
- Synchronous reset:
  - state = FETCH, watchdog counter = 0.
  - Outputs therefore reset to ena_ri = 1 and everything else 0; out = 1.
- State codes: PC = 0, FETCH = 1, LDR = 2, ARIT = 3, WB_RD = 4, LOGICA = 5, WB_R0 = 6, JUMP = 7, HALT = 8, FAULT = 9. Codes 10–15 are unreachable and return to FETCH on the next clock.
- Decode in FETCH when ri_ack = 1, using mnm_in[2:0]:
  - 000 LDR → LDR.
  - 001 logic → LOGICA.
  - 010 / 011 arithmetic → ARIT.
  - 100 JMP → JUMP.
  - 101 JZ → JUMP if zero_flag = 1, else PC.
  - 110 NOP → PC.
  - 111 HALT → HALT.
  - If any bit of mnm_in[OPC_W-1:3] is 1 → FAULT.
- Waits (each state holds until its condition, then moves):
  - PC, pc_ack → FETCH.
  - JUMP, pc_ack → FETCH (no increment).
  - LDR, wr_ack → PC.
  - ARIT, ula_ack → WB_RD.
  - WB_RD, wr_ack → PC.
  - LOGICA, ula_ack → WB_R0.
  - WB_R0, wr_ack → PC.
  - HALT, resume → PC.
  - FAULT is left only by rst; resume is ignored there.
- Moore outputs; any output not listed is 0:
  - PC: ena_pc.
  - JUMP: ena_pc, ld_pc.
  - FETCH: ena_ri.
  - LDR: ena_wr, sel_r0_rd, sel_ldr_ula.
  - ARIT: sel_addr_data, ena_ula.
  - WB_RD: ena_wr, sel_r0_rd.
  - LOGICA: sel_addr_data, ena_ula.
  - WB_R0: ena_wr.
  - HALT: halted.
  - FAULT: fault.
- Watchdog (TIMEOUT > 0):
  - Counter width is clog2(TIMEOUT + 1).
  - Counter clears on every state change and on entry to any state.
  - It increments each cycle spent in a waiting state (all states except HALT and FAULT) while that state's ack is low.
  - When the counter equals TIMEOUT-1 and the ack is still low, the next state is FAULT. A state therefore lasts at most TIMEOUT cycles.
  - Ack and timeout in the same cycle: the ack wins and the normal transition is taken.
  - HALT has no timeout.
  - With TIMEOUT = 0 the counter is held at 0 and FAULT is reachable only through an illegal opcode.
- Acks arriving in states that do not wait on them are ignored.
- rst asserted mid-instruction returns to FETCH on the next edge regardless of state or counter value.

Decomposition:
- Package fsm_ctrl_pkg holds:
  - state code localparams, 4 bits;
  - opcode constants OP_LDR … OP_HALT, 3 bits;
  - state width constant 4.
- One sub-module, ack_watchdog: parameter TIMEOUT; inputs clk, rst, clr, wait_en, ack; output expire.
  - Instantiated once. clr is driven by the state-change strobe.

Test Plan:
- Reset, then LDR (mnm_in = 000, ri_ack = 1), then wr_ack = 1, then pc_ack = 1 → out sequence 1, 2, 0, 1. In state 2: ena_wr = 1, sel_r0_rd = 1, sel_ldr_ula = 1.
- ADD (010) with ula_ack delayed 3 cycles → out stays 3 for 4 cycles, then 4, then 0 after wr_ack. ena_ula = 1 only while in state 3.
- JZ (101): with zero_flag = 1 → state 7 with ld_pc = 1 and ena_pc = 1, then pc_ack → state 1. With zero_flag = 0 → state 0 and ld_pc = 0.
- HALT (111) → out = 8, halted = 1 held for 50 cycles with acks toggling. resume pulse → out = 0.
- TIMEOUT = 4, enter ARIT and never send ula_ack → out = 3 for exactly 4 cycles, then 9 with fault = 1. fault stays set through resume; rst → out = 1.
- OPC_W = 4, mnm_in = 1000 with ri_ack → FAULT (out = 9). Separately, ula_ack arriving in the same cycle the counter reaches TIMEOUT-1 → WB_RD, not FAULT.
